// File: rtl/dsp_mul_arb_pkg.sv
// Shared widths and round-robin search helper for the shared signed DSP multiplier arbiter.
package dsp_mul_arb_pkg;

    localparam int unsigned A_W_DEF  = 20;
    localparam int unsigned B_W_DEF  = 18;
    localparam int unsigned P_W      = A_W_DEF + B_W_DEF;
    localparam int unsigned MAX_REQ  = 8;
    localparam int unsigned MAX_ID_W = 3;

    typedef struct packed {
        logic                found;
        logic [MAX_ID_W-1:0] idx;
    } rr_pick_t;

    // First set bit of valid searching from ptr+1 upward, wrapping modulo n.
    function automatic rr_pick_t rr_next(
        input logic [MAX_ID_W-1:0] ptr,
        input logic [MAX_REQ-1:0]  valid,
        input int unsigned         n
    );
        rr_pick_t    pick;
        int unsigned cand;
        pick = '0;
        for (int unsigned k = 1; k <= MAX_REQ; k++) begin
            cand = (32'(ptr) + k) % n;
            if (k <= n && !pick.found && valid[cand[MAX_ID_W-1:0]]) begin
                pick.found = 1'b1;
                pick.idx   = cand[MAX_ID_W-1:0];
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/dsp_mul_rr_arbiter.sv
// Combinational round-robin grant: priority starts just after the last granted index.
module dsp_mul_rr_arbiter
    import dsp_mul_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic [ID_W-1:0]    ptr,
    input  logic [NUM_REQ-1:0] req_valid,
    output logic [NUM_REQ-1:0] grant_onehot,
    output logic [ID_W-1:0]    grant_idx,
    output logic               grant_any
);

    rr_pick_t pick;

    always_comb begin
        pick         = rr_next(MAX_ID_W'(ptr), MAX_REQ'(req_valid), NUM_REQ);
        grant_any    = pick.found;
        grant_idx    = ID_W'(pick.idx);
        grant_onehot = '0;
        if (pick.found) begin
            grant_onehot[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/dsp_mul_signed_arbiter.sv
// Shares one signed A_W x B_W multiplier among NUM_REQ requesters: operand stage, product
// register, results returned in acceptance order tagged with the requester index.
module dsp_mul_signed_arbiter
    import dsp_mul_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned A_W     = A_W_DEF,
    parameter int unsigned B_W     = B_W_DEF,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*A_W-1:0] req_a,
    input  logic [NUM_REQ*B_W-1:0] req_b,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [A_W+B_W-1:0]     res_p,
    output logic [ID_W-1:0]        res_id,
    output logic                   busy
);

    localparam int unsigned RES_W = A_W + B_W;

    logic [ID_W-1:0]         ptr_q, ptr_d;
    logic signed [A_W-1:0]   a_q, a_d;
    logic signed [B_W-1:0]   b_q, b_d;
    logic [ID_W-1:0]         id_q, id_d;
    logic                    v1_q, v1_d;
    logic [RES_W-1:0]        res_p_q, res_p_d;
    logic [ID_W-1:0]         res_id_q, res_id_d;
    logic                    res_valid_q, res_valid_d;

    logic [NUM_REQ-1:0]      grant_onehot;
    logic [ID_W-1:0]         grant_idx;
    logic                    grant_any;
    logic                    s1_load, s2_load, hs;
    logic signed [RES_W-1:0] prod;

    dsp_mul_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr (
        .ptr          (ptr_q),
        .req_valid    (req_valid),
        .grant_onehot (grant_onehot),
        .grant_idx    (grant_idx),
        .grant_any    (grant_any)
    );

    // Pipeline advance, grant capture and full-width signed product.
    always_comb begin
        ptr_d       = ptr_q;
        a_d         = a_q;
        b_d         = b_q;
        id_d        = id_q;
        v1_d        = v1_q;
        res_p_d     = res_p_q;
        res_id_d    = res_id_q;
        res_valid_d = res_valid_q;

        s2_load = v1_q & (~res_valid_q | res_ready);
        s1_load = ~v1_q | s2_load;
        hs      = s1_load & grant_any;
        prod    = RES_W'(a_q) * RES_W'(b_q);

        if (s2_load) begin
            res_valid_d = 1'b1;
            res_p_d     = prod;
            res_id_d    = id_q;
        end else if (res_ready) begin
            res_valid_d = 1'b0;
        end

        if (s1_load) begin
            v1_d = grant_any;
        end

        if (hs) begin
            a_d   = req_a[int'(grant_idx)*A_W +: A_W];
            b_d   = req_b[int'(grant_idx)*B_W +: B_W];
            id_d  = grant_idx;
            ptr_d = grant_idx;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q       <= ID_W'(NUM_REQ - 1);
            a_q         <= '0;
            b_q         <= '0;
            id_q        <= '0;
            v1_q        <= 1'b0;
            res_p_q     <= '0;
            res_id_q    <= '0;
            res_valid_q <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            a_q         <= a_d;
            b_q         <= b_d;
            id_q        <= id_d;
            v1_q        <= v1_d;
            res_p_q     <= res_p_d;
            res_id_q    <= res_id_d;
            res_valid_q <= res_valid_d;
        end
    end

    // An empty operand stage would otherwise advertise ready while reset is held.
    assign req_ready = (reset && s1_load) ? grant_onehot : '0;
    assign res_valid = res_valid_q;
    assign res_p     = res_p_q;
    assign res_id    = res_id_q;
    assign busy      = v1_q | res_valid_q;

endmodule

// File: tb/tb_dsp_mul_signed_arbiter.sv
// Directed and randomized checks of the shared signed multiplier arbiter.
module tb_dsp_mul_signed_arbiter;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned A_W     = 20;
    localparam int unsigned B_W     = 18;
    localparam int unsigned ID_W    = 2;
    localparam int unsigned P_W     = A_W + B_W;

    logic                   clk = 1'b0;
    logic                   reset = 1'b0;
    logic [NUM_REQ-1:0]     req_valid = '0;
    logic [NUM_REQ-1:0]     req_ready;
    logic [NUM_REQ*A_W-1:0] req_a;
    logic [NUM_REQ*B_W-1:0] req_b;
    logic                   res_valid;
    logic                   res_ready = 1'b1;
    logic [P_W-1:0]         res_p;
    logic [ID_W-1:0]        res_id;
    logic                   busy;

    logic signed [A_W-1:0]  a_v [NUM_REQ];
    logic signed [B_W-1:0]  b_v [NUM_REQ];

    typedef struct {
        int     id;
        longint p;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_res    = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_a[i*A_W +: A_W] = a_v[i];
            req_b[i*B_W +: B_W] = b_v[i];
        end
    end

    dsp_mul_signed_arbiter #(
        .NUM_REQ (NUM_REQ),
        .A_W     (A_W),
        .B_W     (B_W),
        .ID_W    (ID_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_p     (res_p),
        .res_id    (res_id),
        .busy      (busy)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Scoreboard: record accepted operand pairs, compare each delivered result in order.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            sb_q.delete();
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    e.id = i;
                    e.p  = longint'(a_v[i]) * longint'(b_v[i]);
                    sb_q.push_back(e);
                end
            end
            if (res_valid && res_ready) begin
                n_res++;
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_result", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    check("sb_res_p", longint'($signed(res_p)), e.p);
                    check("sb_res_id", longint'(res_id), longint'(e.id));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        req_valid = '0;
        res_ready = 1'b1;
        repeat (2) step();
        reset = 1'b1;
    endtask

    task automatic one_shot(input int id, input longint a, input longint b, input longint exp);
        a_v[id]       = A_W'(a);
        b_v[id]       = B_W'(b);
        req_valid     = '0;
        req_valid[id] = 1'b1;
        res_ready     = 1'b1;
        #1;
        check("single_grant", longint'(req_ready), longint'(1) << id);
        step();
        req_valid = '0;
        check("single_t1_res_valid", longint'(res_valid), 0);
        check("single_t1_busy", longint'(busy), 1);
        step();
        check("single_t2_res_valid", longint'(res_valid), 1);
        check("single_res_p", longint'($signed(res_p)), exp);
        check("single_res_id", longint'(res_id), longint'(id));
        step();
        check("single_idle_busy", longint'(busy), 0);
    endtask

    initial begin
        longint             exp_rr [NUM_REQ];
        int                 hs_cnt;
        int                 n0;
        int                 issued;
        int                 cyc;
        logic [NUM_REQ-1:0] acc;

        exp_rr = '{-3000, -8000, -15000, -24000};
        for (int i = 0; i < NUM_REQ; i++) begin
            a_v[i] = '0;
            b_v[i] = '0;
        end

        // Reset state, with requests pending so ready gating is exercised.
        #1;
        step();
        req_valid = '1;
        #1;
        check("rst_req_ready", longint'(req_ready), 0);
        check("rst_res_valid", longint'(res_valid), 0);
        check("rst_busy", longint'(busy), 0);
        check("rst_res_p", longint'(res_p), 0);
        check("rst_res_id", longint'(res_id), 0);
        req_valid = '0;
        reset     = 1'b1;
        step();

        // Latency and signed extremes.
        one_shot(0, 5, 2, 10);
        one_shot(0, -524288, -131072, 64'sd68719476736);
        one_shot(0, -1, 1, -1);
        one_shot(0, 524287, -131072, -64'sd68719345664);

        // Continuous round robin at full throughput.
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) begin
            a_v[i] = A_W'(1000 * (i + 1));
            b_v[i] = B_W'(-(i + 3));
        end
        req_valid = '1;
        res_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            #1;
            check("rr_grant", longint'(req_ready), longint'(1) << (k % 4));
            if (k >= 2) begin
                check("rr_res_valid", longint'(res_valid), 1);
                check("rr_res_id", longint'(res_id), longint'((k - 2) % 4));
                check("rr_res_p", longint'($signed(res_p)), exp_rr[(k - 2) % 4]);
            end
            step();
        end
        req_valid = '0;
        repeat (3) step();
        check("rr_drain_busy", longint'(busy), 0);

        // Backpressure with every requester pending.
        do_reset();
        req_valid = '1;
        res_ready = 1'b0;
        hs_cnt    = 0;
        for (int k = 0; k < 4; k++) begin
            #1;
            if (req_ready != '0) hs_cnt++;
            if (k >= 2) begin
                check("bp_ready_zero", longint'(req_ready), 0);
                check("bp_hold_res_p", longint'($signed(res_p)), -3000);
                check("bp_hold_res_id", longint'(res_id), 0);
            end
            step();
        end
        check("bp_handshakes", longint'(hs_cnt), 2);
        n0        = n_res;
        req_valid = '0;
        res_ready = 1'b1;
        repeat (3) step();
        check("bp_delivered", longint'(n_res - n0), 2);
        check("bp_sb_empty", longint'(sb_q.size()), 0);

        // Reset with two products in flight.
        do_reset();
        req_valid = '1;
        res_ready = 1'b0;
        repeat (2) step();
        check("mid_busy_before", longint'(busy), 1);
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_res_valid", longint'(res_valid), 0);
        check("mid_rst_busy", longint'(busy), 0);
        check("mid_rst_req_ready", longint'(req_ready), 0);
        step();
        req_valid = 4'b0101;
        res_ready = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        check("mid_first_grant", longint'(req_ready), 1);
        step();
        req_valid = 4'b0100;
        #1;
        check("mid_second_grant", longint'(req_ready), 4);
        step();
        req_valid = '0;
        repeat (3) step();
        check("mid_drain_busy", longint'(busy), 0);
        check("mid_sb_empty", longint'(sb_q.size()), 0);

        // Random operands, random requesters, random backpressure.
        n0     = n_res;
        issued = 0;
        cyc    = 0;
        while ((issued < 32 || req_valid != '0) && cyc < 2000) begin
            res_ready = 1'($urandom_range(0, 1));
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!req_valid[i] && issued < 32 && $urandom_range(0, 1) == 1) begin
                    a_v[i]       = A_W'($urandom);
                    b_v[i]       = B_W'($urandom);
                    req_valid[i] = 1'b1;
                    issued++;
                end
            end
            #1;
            acc = req_valid & req_ready;
            step();
            req_valid = req_valid & ~acc;
            cyc++;
        end
        check("rand_issue_timeout", longint'(cyc < 2000), 1);
        res_ready = 1'b1;
        cyc       = 0;
        while (busy && cyc < 20) begin
            step();
            cyc++;
        end
        step();
        check("rand_drain_busy", longint'(busy), 0);
        check("rand_sb_empty", longint'(sb_q.size()), 0);
        check("rand_result_count", longint'(n_res - n0), 32);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
